// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Captures pipeline_alu results {result, zero, cf} into a small circular FIFO.
//   The FIFO head is presented to a consumer through a valid/ready handshake.
//   Operations still inside the ALU are tracked so that o_can_issue can hold
//   off the issuer before the FIFO could overflow.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_issue               one op entered pipeline_alu this cycle
//   i_valid, i_result,
//   i_zero, i_cf          pipeline_alu output beat
//   i_rd_ready            consumer ready
//   o_rd_valid/result/
//   o_rd_zero/o_rd_cf     FIFO head; data reads 0 while empty
//   o_count               stored entries, 0..DEPTH
//   o_can_issue           a new op may be issued this cycle
//   o_overflow            sticky: a result was dropped while full
//
// Optional build macro RESFIFO_STATS_EN adds o_push_cnt / o_drop_cnt
// (16-bit wrapping counters of accepted and dropped results).

`ifndef WORD
`define WORD 8
`endif

module alu_result_fifo #(
  parameter int WIDTH = `WORD,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_issue,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_zero,
  input  logic             i_cf,
  input  logic             i_rd_ready,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_result,
  output logic             o_rd_zero,
  output logic             o_rd_cf,
  output logic [CW-1:0]    o_count,
  output logic             o_can_issue,
  output logic             o_overflow
`ifdef RESFIFO_STATS_EN
  ,
  output logic [15:0]      o_push_cnt,
  output logic [15:0]      o_drop_cnt
`endif
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_S = (CW+1)'(DEPTH);

  logic [WIDTH+1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, infl_q, infl_d;
  logic             ovf_q, ovf_d;
  logic             full, push, pop, drop;
  logic [WIDTH+1:0] head;

  always_comb begin
    full     = (count_q == DEPTH_C);
    pop      = (count_q != '0) && i_rd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push     = i_valid && (!full || pop);
    drop     = i_valid && full && !pop;
    // DEPTH is a power of two, so the pointers wrap on their own.
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // In-flight ops: issue and completion in the same cycle cancel out.
    // A stray completion with nothing in flight leaves the count at 0.
    infl_d = infl_q;
    if (i_issue && !i_valid && infl_q != DEPTH_C)
      infl_d = infl_q + 1'b1;
    else if (!i_issue && i_valid && infl_q != '0)
      infl_d = infl_q - 1'b1;
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the head outputs are masked while empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) mem_q[wr_ptr_q] <= {i_result, i_zero, i_cf};
  end

  assign head        = mem_q[rd_ptr_q];
  assign o_rd_valid  = (count_q != '0);
  assign o_rd_result = o_rd_valid ? head[WIDTH+1:2] : '0;
  assign o_rd_zero   = o_rd_valid ? head[1] : 1'b0;
  assign o_rd_cf     = o_rd_valid ? head[0] : 1'b0;
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  // A pop frees its slot only once count_q updates, i.e. next cycle.
  assign o_can_issue = ({1'b0, count_q} + {1'b0, infl_q}) < DEPTH_S;

`ifdef RESFIFO_STATS_EN
  logic [15:0] push_cnt_q, drop_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) push_cnt_q <= push_cnt_q + 16'd1;
      if (drop) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_push_cnt = push_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo. A one-stage pipeline_alu stand-in feeds the DUT;
// a direct injection path (frc_v) drives stray/forced results.
module tb_alu_result_fifo;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam logic [1:0] OP_SUM = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_XOR = 2'd3;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, iss, frc_v, rdy;
  logic [1:0]    op;
  logic [7:0]    a, b;
  ent_t          frc_e, alu_e, exp_e;
  logic          alu_v;
  logic          rd_valid, rd_zero, rd_cf, can_issue, overflow;
  logic [7:0]    rd_result;
  logic [CW-1:0] count;
  logic          dut_valid;
  ent_t          dut_in;
`ifdef RESFIFO_STATS_EN
  logic [15:0]   push_cnt, drop_cnt;
`endif

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic ent_t alu(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    ent_t e;
    logic [8:0] s;
    e = '0;
    case (o)
      OP_SUM: begin s = {1'b0, x} + {1'b0, y}; e.r = s[7:0]; e.c = s[8]; end
      OP_SUB: begin e.r = x - y; e.c = (x < y); end
      OP_AND: e.r = x & y;
      default: e.r = x ^ y;
    endcase
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  // pipeline_alu stand-in: one register stage from issue to o_valid.
  always_ff @(posedge clk) begin
    alu_v <= iss;
    alu_e <= alu(op, a, b);
  end

  assign dut_valid = alu_v | frc_v;
  assign dut_in    = frc_v ? frc_e : alu_e;

  alu_result_fifo #(.WIDTH(8), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_issue(iss), .i_valid(dut_valid),
    .i_result(dut_in.r), .i_zero(dut_in.z), .i_cf(dut_in.c),
    .i_rd_ready(rdy), .o_rd_valid(rd_valid), .o_rd_result(rd_result),
    .o_rd_zero(rd_zero), .o_rd_cf(rd_cf), .o_count(count),
    .o_can_issue(can_issue), .o_overflow(overflow)
`ifdef RESFIFO_STATS_EN
    , .o_push_cnt(push_cnt), .o_drop_cnt(drop_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op into the ALU for the coming edge; expected result queued now.
  task automatic issue_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y; iss = 1'b1;
    sb.push_back(alu(o, x, y));
  endtask

  task automatic test_reset();
    rst = 1'b1; iss = 1'b0; frc_v = 1'b0; rdy = 1'b0; op = '0; a = '0; b = '0; frc_e = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (can_issue !== 1'b1) begin errors++; $display("FAIL reset_can_issue: got %b want 1", can_issue); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (rd_result !== 8'h00) begin errors++; $display("FAIL reset_rd_result: got %h want 00", rd_result); end
  endtask

  task automatic test_sum();
    issue_op(OP_SUM, 8'd2, 8'd2);
    tick(); iss = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL sum_no_bypass: got %b want 0", rd_valid); end
    tick();
    exp_e = sb[0];
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({rd_valid, rd_result, rd_zero, rd_cf} !== {1'b1, 8'd4, 1'b0, 1'b0} ||
          {rd_result, rd_zero, rd_cf} !== exp_e) begin
        errors++;
        $display("FAIL sum_head_hold[%0d]: got v=%b r=%h z=%b c=%b want v=1 r=04 z=0 c=0", i, rd_valid, rd_result, rd_zero, rd_cf);
      end
      if (i < 5) tick();
    end
    rdy = 1'b1; void'(sb.pop_front());
    tick(); rdy = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sum_pop_count: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4];
    want[0] = 8'h3F; want[1] = 8'h04; want[2] = 8'h05; want[3] = 8'h00;
    issue_op(OP_XOR, 8'h3C, 8'h03); tick();
    issue_op(OP_AND, 8'h3C, 8'h04); tick();
    issue_op(OP_SUB, 8'd7, 8'd2);   tick();
    checks++; if (can_issue !== 1'b1) begin errors++; $display("FAIL b2b_can_issue_3: got %b want 1", can_issue); end
    issue_op(OP_SUB, 8'd2, 8'd2);   tick();
    iss = 1'b0;
    checks++; if (can_issue !== 1'b0) begin errors++; $display("FAIL b2b_can_issue_4: got %b want 0", can_issue); end
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_count_full: got %0d want 4", count); end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_e = sb.pop_front();
      checks++;
      if (!rd_valid || rd_result !== want[i] || {rd_result, rd_zero, rd_cf} !== exp_e ||
          rd_zero !== (i == 3)) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: got v=%b r=%h z=%b want r=%h z=%b", i, rd_valid, rd_result, rd_zero, want[i], (i == 3));
      end
      tick();
    end
    rdy = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_count_empty: got %0d want 0", count); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      issue_op(OP_SUM, 8'(i * 16), 8'd1); tick();
    end
    iss = 1'b0; tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_fill: got %0d want 4", count); end
    frc_v = 1'b1; frc_e = '{r: 8'hA5, z: 1'b0, c: 1'b1}; rdy = 1'b1;
    exp_e = sb.pop_front();
    checks++;
    if ({rd_result, rd_zero, rd_cf} !== exp_e) begin
      errors++; $display("FAIL fullpop_head: got %h want %h", {rd_result, rd_zero, rd_cf}, exp_e);
    end
    sb.push_back(frc_e);
    tick(); frc_v = 1'b0; rdy = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d want 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    frc_v = 1'b1; frc_e = '{r: 8'h5A, z: 1'b0, c: 1'b0};
    tick(); frc_v = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count); end
`ifdef RESFIFO_STATS_EN
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
`endif
    tick(); tick(); tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    // Dropped word must not appear; tail is the entry written alongside a pop.
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_e = sb.pop_front();
      checks++;
      if (!rd_valid || {rd_result, rd_zero, rd_cf} !== exp_e) begin
        errors++; $display("FAIL ovf_drain[%0d]: got v=%b %h want %h", i, rd_valid, {rd_result, rd_zero, rd_cf}, exp_e);
      end
      tick();
    end
    rdy = 1'b0;
    checks++; if (rd_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain: got v=%b ovf=%b want v=0 ovf=1", rd_valid, overflow); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      issue_op(OP_XOR, 8'(i + 1), 8'h80); tick();
    end
    iss = 1'b0; tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mrst_fill: got %0d want 3", count); end
    issue_op(OP_SUM, 8'd9, 8'd9); tick(); iss = 1'b0;
    checks++; if (can_issue !== 1'b0) begin errors++; $display("FAIL mrst_inflight: got can_issue=%b want 0", can_issue); end
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mrst_count: got %0d want 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mrst_rd_valid: got %b want 0", rd_valid); end
    checks++; if (can_issue !== 1'b1) begin errors++; $display("FAIL mrst_can_issue: got %b want 1", can_issue); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mrst_overflow: got %b want 0", overflow); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mrst_settle: got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      issue_op(OP_XOR, 8'(i * 17), 8'h55); tick(); iss = 1'b0;
      tick();
      exp_e = sb.pop_front();
      checks++;
      if (!rd_valid || {rd_result, rd_zero, rd_cf} !== exp_e) begin
        errors++; $display("FAIL wrap[%0d]: got v=%b %h want %h", i, rd_valid, {rd_result, rd_zero, rd_cf}, exp_e);
      end
      rdy = 1'b1; tick(); rdy = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 0", i, count); end
    end
`ifdef RESFIFO_STATS_EN
    checks++; if (push_cnt !== 16'd10) begin errors++; $display("FAIL wrap_push_cnt: got %0d want 10", push_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_sum();
    test_back_to_back();
    test_full_pop();
    test_overflow();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
